// File: rtl/sbox_lookup_scheduler.sv
// Shares one LANES-wide S-box lookup port between 128-bit SubBytes and 32-bit SubWord
// requests, splitting each request into byte-lane beats and reassembling a registered response.
module sbox_lookup_scheduler #(
  parameter int LANES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 state_req_valid,
  output logic                 state_req_ready,
  input  logic [127:0]         state_req_data,
  output logic                 state_rsp_valid,
  output logic [127:0]         state_rsp_data,
  input  logic                 key_req_valid,
  output logic                 key_req_ready,
  input  logic [31:0]          key_req_data,
  output logic                 key_rsp_valid,
  output logic [31:0]          key_rsp_data,
  output logic [8*LANES-1:0]   sbox_addr,
  input  logic [8*LANES-1:0]   sbox_data,
  output logic                 busy
);

  localparam int STATE_BEATS = 16 / LANES;
  localparam int KEY_BEATS   = 4 / LANES;

  typedef enum logic {IDLE, BUSY} fsm_e;

  fsm_e              state_q;
  logic              pri_key_q;
  logic              owner_key_q;
  logic [3:0]        beat_q;
  logic [15:0][7:0]  buf_q;
  logic [15:0][7:0]  res_q;
  logic [15:0][7:0]  res_d;
  logic              state_rsp_valid_q;
  logic              key_rsp_valid_q;
  logic [127:0]      state_rsp_data_q;
  logic [31:0]       key_rsp_data_q;

  logic              grant_key;
  logic              grant_state;
  logic [3:0]        last_beat;
  logic [3:0]        byte_base;

  // Key wins a tie only when it holds priority; the winner hands priority to the other side.
  assign grant_key   = key_req_valid && (!state_req_valid || pri_key_q);
  assign grant_state = state_req_valid && !grant_key;

  assign state_req_ready = (state_q == IDLE) && !rst;
  assign key_req_ready   = (state_q == IDLE) && !rst;
  assign busy            = (state_q == BUSY);
  assign last_beat       = owner_key_q ? 4'(KEY_BEATS - 1) : 4'(STATE_BEATS - 1);
  assign byte_base       = 4'(beat_q * 4'(LANES));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sbox_addr = '0;
    res_d     = res_q;
    if (state_q == BUSY) begin
      for (int j = 0; j < LANES; j++) begin
        sbox_addr[8*j +: 8]    = buf_q[byte_base + 4'(j)];
        res_d[byte_base + 4'(j)] = sbox_data[8*j +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= IDLE;
      pri_key_q         <= 1'b1;
      owner_key_q       <= 1'b0;
      beat_q            <= '0;
      state_rsp_valid_q <= 1'b0;
      key_rsp_valid_q   <= 1'b0;
      state_rsp_data_q  <= '0;
      key_rsp_data_q    <= '0;
    end else begin
      state_rsp_valid_q <= 1'b0;
      key_rsp_valid_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_key || grant_state) begin
            owner_key_q <= grant_key;
            pri_key_q   <= grant_state;
            beat_q      <= '0;
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          beat_q <= beat_q + 4'd1;
          if (beat_q == last_beat) begin
            state_q <= IDLE;
            if (owner_key_q) begin
              key_rsp_valid_q <= 1'b1;
              key_rsp_data_q  <= res_d[3:0];
            end else begin
              state_rsp_valid_q <= 1'b1;
              state_rsp_data_q  <= res_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: the input buffer and result scratch are pure datapath, fully rewritten before use, so no reset.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && (grant_key || grant_state)) begin
      buf_q <= grant_key ? {96'b0, key_req_data} : state_req_data;
    end
    if (state_q == BUSY) begin
      res_q <= res_d;
    end
  end

  assign state_rsp_valid = state_rsp_valid_q;
  assign key_rsp_valid   = key_rsp_valid_q;
  assign state_rsp_data  = state_rsp_data_q;
  assign key_rsp_data    = key_rsp_data_q;

endmodule

// File: tb/tb_sbox_lookup_scheduler.sv
// Randomized bench for sbox_lookup_scheduler: a transaction-level model predicts grants,
// beat addresses and response timing/data from the arbitration and latency rules.
module tb_sbox_lookup_scheduler;

  localparam int LANES       = 4;
  localparam int STATE_BEATS = 16 / LANES;
  localparam int KEY_BEATS   = 4 / LANES;

  logic                clk = 1'b0;
  logic                rst;
  logic                state_req_valid, state_req_ready, state_rsp_valid;
  logic [127:0]        state_req_data, state_rsp_data;
  logic                key_req_valid, key_req_ready, key_rsp_valid;
  logic [31:0]         key_req_data, key_rsp_data;
  logic [8*LANES-1:0]  sbox_addr, sbox_data;
  logic                busy;

  always #5 clk = ~clk;

  logic [7:0] sbox_tab [256];

  for (genvar j = 0; j < LANES; j++) begin : g_sbox
    assign sbox_data[8*j +: 8] = sbox_tab[sbox_addr[8*j +: 8]];
  end

  sbox_lookup_scheduler #(.LANES(LANES)) dut (
    .clk             (clk),
    .rst             (rst),
    .state_req_valid (state_req_valid),
    .state_req_ready (state_req_ready),
    .state_req_data  (state_req_data),
    .state_rsp_valid (state_rsp_valid),
    .state_rsp_data  (state_rsp_data),
    .key_req_valid   (key_req_valid),
    .key_req_ready   (key_req_ready),
    .key_req_data    (key_req_data),
    .key_rsp_valid   (key_rsp_valid),
    .key_rsp_data    (key_rsp_data),
    .sbox_addr       (sbox_addr),
    .sbox_data       (sbox_data),
    .busy            (busy)
  );

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  // Reference model state (transaction level).
  int               free_at  = 0;
  bit               m_pri    = 1'b1;
  int               op_start = 0;
  logic [15:0][7:0] op_data  = '0;
  int               rsp_at   = -1;
  bit               rsp_key  = 1'b0;
  logic [127:0]     rsp_val  = '0;
  logic [127:0]     last_state = '0;
  logic [31:0]      last_key   = '0;
  bit               hs_s, hs_k;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] r, s;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      r = inv;
      s = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s ^= r;
      end
      sbox_tab[a] = s ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] subst(input logic [127:0] d);
    logic [15:0][7:0] v = d;
    logic [15:0][7:0] o;
    for (int i = 0; i < 16; i++) o[i] = sbox_tab[v[i]];
    return o;
  endfunction

  // One clock cycle: compare outputs against the model, evaluate the handshake, advance.
  task automatic step();
    bit               ready_exp;
    logic [8*LANES-1:0] addr_exp;
    int               k;
    @(negedge clk);
    hs_s = 1'b0;
    hs_k = 1'b0;
    if (rst) begin
      check("ready_in_rst", {state_req_ready, key_req_ready}, 2'b00);
      free_at    = cyc + 1;
      rsp_at     = -1;
      m_pri      = 1'b1;
      last_state = '0;
      last_key   = '0;
    end else begin
      ready_exp = (cyc >= free_at);
      addr_exp  = '0;
      if (!ready_exp) begin
        k = cyc - op_start - 1;
        for (int j = 0; j < LANES; j++) addr_exp[8*j +: 8] = op_data[k*LANES + j];
      end
      if (rsp_at == cyc) begin
        if (rsp_key) last_key = rsp_val[31:0];
        else         last_state = rsp_val;
      end
      check("state_ready", state_req_ready, ready_exp);
      check("key_ready",   key_req_ready,   ready_exp);
      check("busy",        busy,            !ready_exp);
      check("sbox_addr",   sbox_addr,       addr_exp);
      check("state_rsp_valid", state_rsp_valid, (rsp_at == cyc) && !rsp_key);
      check("key_rsp_valid",   key_rsp_valid,   (rsp_at == cyc) && rsp_key);
      check("state_rsp_data",  state_rsp_data,  last_state);
      check("key_rsp_data",    key_rsp_data,    last_key);
      if (ready_exp) begin
        hs_k = key_req_valid && (!state_req_valid || m_pri);
        hs_s = state_req_valid && !hs_k;
        if (hs_k || hs_s) begin
          op_start = cyc;
          op_data  = hs_k ? {96'b0, key_req_data} : state_req_data;
          free_at  = cyc + (hs_k ? KEY_BEATS : STATE_BEATS) + 1;
          rsp_at   = free_at;
          rsp_key  = hs_k;
          rsp_val  = subst(op_data);
          m_pri    = hs_s;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic req_state(input logic [127:0] d);
    bit done = 1'b0;
    state_req_valid = 1'b1;
    state_req_data  = d;
    for (int i = 0; i < 64; i++) begin
      step();
      if (hs_s) begin
        done = 1'b1;
        break;
      end
    end
    state_req_valid = 1'b0;
    check("state_grant", done, 1'b1);
  endtask

  task automatic req_key(input logic [31:0] d);
    bit done = 1'b0;
    key_req_valid = 1'b1;
    key_req_data  = d;
    for (int i = 0; i < 64; i++) begin
      step();
      if (hs_k) begin
        done = 1'b1;
        break;
      end
    end
    key_req_valid = 1'b0;
    check("key_grant", done, 1'b1);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    rst             = 1'b1;
    state_req_valid = 1'b0;
    state_req_data  = '0;
    key_req_valid   = 1'b0;
    key_req_data    = '0;
    build_sbox();

    idle(2);
    rst = 1'b0;
    idle(1);

    req_state('0);
    idle(6);
    check("zero_state_const", state_rsp_data, {16{8'h63}});

    req_key(32'h53530001);
    idle(3);
    check("key_const", key_rsp_data, 32'hEDED637C);

    // Abort a state request during its third beat.
    req_state(rand128());
    idle(2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(2);
    check("abort_state_data", state_rsp_data, 128'h0);
    check("abort_key_data",   key_rsp_data,   32'h0);

    // Both requesters continuously valid: grants alternate starting with key.
    state_req_valid = 1'b1;
    state_req_data  = rand128();
    key_req_valid   = 1'b1;
    key_req_data    = $urandom;
    for (int i = 0; i < 16; i++) begin
      step();
      if (hs_s) state_req_data = rand128();
      if (hs_k) key_req_data = $urandom;
    end
    state_req_valid = 1'b0;
    key_req_valid   = 1'b0;
    idle(8);

    req_state({16{8'hFF}});
    req_state({16{8'h01}});
    check("b2b_first_const", state_rsp_data, {16{8'h16}});
    idle(6);
    check("b2b_second_const", state_rsp_data, {16{8'h7C}});

    // Random traffic with occasional withdrawals and resets.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      step();
      if (hs_s) begin
        state_req_valid = $urandom_range(0, 1) == 1;
        state_req_data  = rand128();
      end else if (state_req_valid && $urandom_range(0, 15) == 0) begin
        state_req_valid = 1'b0;
      end else if (!state_req_valid && $urandom_range(0, 2) == 0) begin
        state_req_valid = 1'b1;
        state_req_data  = rand128();
      end
      if (hs_k) begin
        key_req_valid = $urandom_range(0, 1) == 1;
        key_req_data  = $urandom;
      end else if (key_req_valid && $urandom_range(0, 15) == 0) begin
        key_req_valid = 1'b0;
      end else if (!key_req_valid && $urandom_range(0, 2) == 0) begin
        key_req_valid = 1'b1;
        key_req_data  = $urandom;
      end
    end
    rst             = 1'b0;
    state_req_valid = 1'b0;
    key_req_valid   = 1'b0;
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
